stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_seq_pkg.sv | 26 ++
 rtl/stage_timer.sv | 55 +++++
 rtl/stage_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_stage_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_seq_pkg.sv
// -----------------------------------------------------------------------------
// stage_seq_pkg
// Shared definitions for the stage sequencer:
//   - state_e       : 3-bit FSM state encoding, IDLE = 0
//   - TMO_W_DEFAULT : default width of the per-stage timeout counter
//   - idx_width()   : width of a stage index (clog2, never below 1)
// -----------------------------------------------------------------------------
package stage_seq_pkg;

    localparam int TMO_W_DEFAULT    = 8;
    localparam int N_STAGES_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    // A single-stage build still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stage_timer.sv
// -----------------------------------------------------------------------------
// stage_timer
// Per-stage wait timer: cleared by 'clear', counts up by one while 'enable'
// is high and saturates at all-ones. 'hit' flags count == limit for a
// nonzero limit (a zero limit means "no timeout").
//
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : synchronous active-high reset (count -> 0)
//   clear  in  : synchronous clear, wins over enable
//   enable in  : count-up request
//   limit  in  : [TMO_W-1:0] compare value, 0 disables 'hit'
//   count  out : [TMO_W-1:0] current count
//   hit    out : count has reached a nonzero limit
// -----------------------------------------------------------------------------
module stage_timer
    import stage_seq_pkg::*;
#(
    parameter int TMO_W = TMO_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic [TMO_W-1:0] count,
    output logic             hit
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // if/else of the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Moore FSM that runs N_STAGES stages in order. Each stage gets a one-cycle
// start_out pulse, then the FSM waits for that stage's done_in bit. After the
// last stage a one-cycle Done pulse is produced. abort returns to IDLE from
// any active state and from ERROR.
//
// Build option SEQ_TIMEOUT_EN: when defined, a stage_timer bounds each WAIT;
// reaching a nonzero timeout_lim without done moves to ERROR and records the
// stage in err_stage. When undefined there is no timer, ERROR is unreachable
// and err / err_stage are constant 0.
//
// Ports:
//   clk         in  : clock, rising edge
//   reset       in  : synchronous active-high reset
//   start       in  : run request, only honoured in IDLE
//   abort       in  : terminate request, beats done_in
//   done_in     in  : [N_STAGES-1:0] per-stage completion, only the current
//                     stage's bit is looked at
//   timeout_lim in  : [TMO_W-1:0] per-stage wait limit, 0 = no timeout
//   start_out   out : [N_STAGES-1:0] one-hot start pulse for current stage
//   busy        out : high in START, WAIT and DONE
//   stage_idx   out : [IDX_W-1:0] current stage
//   Done        out : one-cycle sequence-complete pulse
//   err         out : timeout error, held until the next accepted start
//   err_stage   out : [IDX_W-1:0] stage that timed out
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter  int N_STAGES = N_STAGES_DEFAULT,
    parameter  int TMO_W    = TMO_W_DEFAULT,
    localparam int IDX_W    = idx_width(N_STAGES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [N_STAGES-1:0] done_in,
    input  logic [TMO_W-1:0]    timeout_lim,
    output logic [N_STAGES-1:0] start_out,
    output logic                busy,
    output logic [IDX_W-1:0]    stage_idx,
    output logic                Done,
    output logic                err,
    output logic [IDX_W-1:0]    err_stage
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] stage_q, stage_d;
    logic             timeout_hit;
    logic             last_stage;

    assign last_stage = (stage_q == IDX_W'(N_STAGES - 1));

`ifdef SEQ_TIMEOUT_EN
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_stage_q, err_stage_d;
    logic             tmr_clear;
    logic             tmr_enable;
    logic [TMO_W-1:0] tmr_count;

    // The timer is cleared while the pulse goes out, so the first WAIT cycle
    // sees a count of 0.
    assign tmr_clear  = (state_q == ST_START);
    assign tmr_enable = (state_q == ST_WAIT);

    stage_timer #(
        .TMO_W (TMO_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .limit  (timeout_lim),
        .count  (tmr_count),
        .hit    (timeout_hit)
    );
`else
    logic unused_timeout_lim;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_lim = ^timeout_lim;
`endif

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
`ifdef SEQ_TIMEOUT_EN
        err_d       = err_q;
        err_stage_d = err_stage_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    stage_d = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_START: begin
                state_d = abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // Priority: abort, then done, then timeout.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (done_in[stage_q]) begin
                    if (last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_START;
                        stage_d = stage_q + IDX_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
`ifdef SEQ_TIMEOUT_EN
                    err_d       = 1'b1;
                    err_stage_d = stage_q;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign err       = err_q;
    assign err_stage = err_stage_q;
`else
    assign err       = 1'b0;
    assign err_stage = '0;
`endif

    // Outputs decode only from registered state.
    always_comb begin
        start_out = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            start_out[i] = (state_q == ST_START) && (stage_q == IDX_W'(i));
        end
    end

    assign busy      = (state_q == ST_START) || (state_q == ST_WAIT) ||
                       (state_q == ST_DONE);
    assign Done      = (state_q == ST_DONE);
    assign stage_idx = stage_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Directed bench for stage_sequencer (N_STAGES=3, TMO_W=8). Inputs are driven
// and outputs sampled 1 time unit after each rising edge. Timeout scenarios
// run when SEQ_TIMEOUT_EN is defined; otherwise a long WAIT checks that no
// error can be raised.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] done_in;
    logic [7:0] timeout_lim;
    logic [2:0] start_out;
    logic       busy;
    logic [1:0] stage_idx;
    logic       Done;
    logic       err;
    logic [1:0] err_stage;

    int n_cmp = 0;
    int n_err = 0;

    stage_sequencer #(
        .N_STAGES (3),
        .TMO_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .done_in     (done_in),
        .timeout_lim (timeout_lim),
        .start_out   (start_out),
        .busy        (busy),
        .stage_idx   (stage_idx),
        .Done        (Done),
        .err         (err),
        .err_stage   (err_stage)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " stage_idx"}, 32'(stage_idx), 32'd0);
        check({tag, " Done"},      32'(Done),      32'd0);
        check({tag, " start_out"}, 32'(start_out), 32'd0);
        check({tag, " err"},       32'(err),       32'd0);
        check({tag, " err_stage"}, 32'(err_stage), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        done_in     = 3'b000;
        timeout_lim = 8'd0;
        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        // Normal run: each done returned in the WAIT cycle after its pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("run start_out s%0d", s), 32'(start_out), 32'(1 << s));
            check($sformatf("run stage_idx s%0d", s), 32'(stage_idx), 32'(s));
            check($sformatf("run busy s%0d", s),      32'(busy),      32'd1);
            tick();
            check($sformatf("run wait start_out s%0d", s), 32'(start_out), 32'd0);
            check($sformatf("run wait Done s%0d", s),      32'(Done),      32'd0);
            done_in = 3'(1 << s);
            tick();
            done_in = 3'b000;
        end
        check("run Done",           32'(Done),      32'd1);
        check("run Done busy",      32'(busy),      32'd1);
        check("run Done start_out", 32'(start_out), 32'd0);
        tick();
        check("run after Done", 32'(Done), 32'd0);
        check("run after busy", 32'(busy), 32'd0);

        // done_in held high: cycle k after the accept edge (k = 1..7) is
        // START(i) for k = 2i+1, WAIT for even k, and DONE at k = 7.
        done_in = 3'b111;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("held start_out k%0d", k), 32'(start_out),
                  (k % 2 == 1 && k < 7) ? 32'(1 << ((k - 1) / 2)) : 32'd0);
            check($sformatf("held Done k%0d", k), 32'(Done), (k == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check("held end busy", 32'(busy), 32'd0);
        check("held end Done", 32'(Done), 32'd0);
        done_in = 3'b000;

        // start held through the run is ignored; abort beats done_in[2].
        start = 1'b1;
        tick();
        tick();
        check("restart wait stage",     32'(stage_idx), 32'd0);
        check("restart wait start_out", 32'(start_out), 32'd0);
        done_in = 3'b001;
        tick();
        done_in = 3'b000;
        check("restart stage1", 32'(stage_idx), 32'd1);
        tick();
        done_in = 3'b010;
        tick();
        done_in = 3'b000;
        tick();
        check("abort pre stage", 32'(stage_idx), 32'd2);
        check("abort pre busy",  32'(busy),      32'd1);
        start   = 1'b0;
        abort   = 1'b1;
        done_in = 3'b100;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort Done", 32'(Done), 32'd0);
        abort   = 1'b0;
        done_in = 3'b000;
        tick();
        check("abort later Done", 32'(Done), 32'd0);
        check("abort later busy", 32'(busy), 32'd0);

        // Reset in the middle of WAIT for stage 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        done_in = 3'b001;
        tick();
        done_in = 3'b000;
        tick();
        tick();
        check("midreset pre stage", 32'(stage_idx), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_values("midreset");
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("postreset start_out", 32'(start_out), 32'd1);
        check("postreset stage",     32'(stage_idx), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("postreset abort busy", 32'(busy), 32'd0);

`ifdef SEQ_TIMEOUT_EN
        // Stage 1 never completes, limit 5.
        timeout_lim = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        done_in = 3'b001;
        tick();
        done_in = 3'b000;
        tick();
        // WAIT(1) with timer 0; the edge leaving timer 5 goes to ERROR.
        repeat (5) tick();
        check("tmo pre err",  32'(err),  32'd0);
        check("tmo pre busy", 32'(busy), 32'd1);
        tick();
        check("tmo err",       32'(err),       32'd1);
        check("tmo err_stage", 32'(err_stage), 32'd1);
        check("tmo busy",      32'(busy),      32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tmo start ignored busy", 32'(busy), 32'd0);
        check("tmo start ignored err",  32'(err),  32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("tmo abort err held", 32'(err),  32'd1);
        check("tmo abort busy",     32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tmo restart err",       32'(err),       32'd0);
        check("tmo restart start_out", 32'(start_out), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // done_in[0] arrives in the same cycle the timer reaches 4.
        timeout_lim = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (4) tick();
        done_in = 3'b001;
        tick();
        done_in = 3'b000;
        check("race stage", 32'(stage_idx), 32'd1);
        check("race err",   32'(err),       32'd0);
        check("race start_out", 32'(start_out), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        timeout_lim = 8'd0;
`else
        // Without the timeout option a long WAIT never raises an error.
        timeout_lim = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (300) tick();
        check("notmo busy",  32'(busy),      32'd1);
        check("notmo err",   32'(err),       32'd0);
        check("notmo stage", 32'(stage_idx), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("notmo abort busy", 32'(busy), 32'd0);
        timeout_lim = 8'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
